// File: rtl/exe_pkg.sv
// exe_pkg: shared ALU command, shift-type and flag-index constants for the execute stage
package exe_pkg;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/val2_generator.sv
// val2_generator: combinational second-operand former (rotated immediate, memory offset or shifted Rm)
module val2_generator
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_rm,
  input  logic [11:0]      shift_operand,
  input  logic             imm,
  input  logic             mem_op,
  output logic [WIDTH-1:0] val2
);
  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [4:0] a);
    return (x >> a) | (x << (WIDTH - int'(a)));
  endfunction
  logic [4:0]       sh;
  logic [1:0]       sh_type;
  logic [WIDTH-1:0] imm_rot, asr;
  always_comb begin
    sh      = shift_operand[11:7];
    sh_type = shift_operand[6:5];
    imm_rot = ror({{(WIDTH-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    asr     = $unsigned($signed(val_rm) >>> sh);
    val2    = imm                ? imm_rot :
              mem_op             ? {{(WIDTH-12){1'b0}}, shift_operand} :
              sh_type == SH_LSL  ? val_rm << sh :
              sh_type == SH_LSR  ? val_rm >> sh :
              sh_type == SH_ASR  ? asr : ror(val_rm, sh);
  end
endmodule

// File: rtl/exe_stage_unit.sv
// exe_stage_unit: ARM-subset execute stage with ALU, NZCV status register, branch resolve and EX/MEM register
// Optional operand forwarding muxes are enabled by defining EXE_FORWARDING_EN.
module exe_stage_unit
  import exe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  carry_in,
  input  logic [WIDTH-1:0]      val_rn_in,
  input  logic [WIDTH-1:0]      val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
`ifdef EXE_FORWARDING_EN
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [WIDTH-1:0]      mem_fwd_val,
  input  logic [WIDTH-1:0]      wb_fwd_val,
`endif
  output logic                  branch_taken,
  output logic [WIDTH-1:0]      branch_addr,
  output logic [3:0]            status,
  output logic [WIDTH-1:0]      alu_res_out,
  output logic [WIDTH-1:0]      val_rm_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out
);
  logic [WIDTH-1:0]      rn, rm, val2, op_b, res;
  logic [WIDTH:0]        sum;
  logic                  cin, sub, arith, known, v;
  logic [3:0]            status_d, status_q;
  logic [WIDTH-1:0]      alu_res_d, alu_res_q, val_rm_d, val_rm_q;
  logic [REG_ADDR_W-1:0] dest_d, dest_q;
  logic                  wb_en_d, wb_en_q, mem_r_en_d, mem_r_en_q, mem_w_en_d, mem_w_en_q;
`ifdef EXE_FORWARDING_EN
  assign rn = sel_src1 == 2'b01 ? mem_fwd_val : sel_src1 == 2'b10 ? wb_fwd_val : val_rn_in;
  assign rm = sel_src2 == 2'b01 ? mem_fwd_val : sel_src2 == 2'b10 ? wb_fwd_val : val_rm_in;
`else
  assign rn = val_rn_in;
  assign rm = val_rm_in;
`endif
  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .val_rm       (rm),
    .shift_operand(shift_operand_in),
    .imm          (imm_in),
    .mem_op       (mem_r_en_in | mem_w_en_in),
    .val2         (val2)
  );
  // Subtraction is Rn + ~Val2 + cin, so C comes out directly as NOT borrow
  always_comb begin
    sub   = exe_cmd_in == CMD_SUB || exe_cmd_in == CMD_SBC;
    arith = sub || exe_cmd_in == CMD_ADD || exe_cmd_in == CMD_ADC;
    known = arith || exe_cmd_in inside {CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR};
    cin   = exe_cmd_in == CMD_SUB ? 1'b1 :
            (exe_cmd_in == CMD_ADC || exe_cmd_in == CMD_SBC) ? carry_in : 1'b0;
    op_b  = sub ? ~val2 : val2;
    sum   = {1'b0, rn} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    v     = (rn[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != rn[WIDTH-1]);
    res   = arith                    ? sum[WIDTH-1:0] :
            exe_cmd_in == CMD_MOV    ? val2 :
            exe_cmd_in == CMD_MVN    ? ~val2 :
            exe_cmd_in == CMD_AND    ? rn & val2 :
            exe_cmd_in == CMD_ORR    ? rn | val2 :
            exe_cmd_in == CMD_EOR    ? rn ^ val2 : '0;
    status_d   = (s_in && !freeze && known) ?
                 {res[WIDTH-1], res == '0, arith ? sum[WIDTH] : status_q[FLAG_C], arith ? v : status_q[FLAG_V]} :
                 status_q;
    alu_res_d  = freeze ? alu_res_q  : res;
    val_rm_d   = freeze ? val_rm_q   : rm;
    dest_d     = freeze ? dest_q     : dest_in;
    wb_en_d    = freeze ? wb_en_q    : wb_en_in;
    mem_r_en_d = freeze ? mem_r_en_q : mem_r_en_in;
    mem_w_en_d = freeze ? mem_w_en_q : mem_w_en_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else begin
      status_q   <= status_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
    end
  end
  assign branch_taken = b_in & ~freeze;
  assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign status       = status_q;
  assign alu_res_out  = alu_res_q;
  assign val_rm_out   = val_rm_q;
  assign dest_out     = dest_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign mem_w_en_out = mem_w_en_q;
endmodule

// File: tb/tb_exe_stage_unit.sv
// tb_exe_stage_unit: directed self-checking bench for exe_stage_unit (default build, no forwarding)
module tb_exe_stage_unit;
  logic        clk = 1'b0, rst, freeze, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, carry_in, imm_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        branch_taken, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] branch_addr, alu_res_out, val_rm_out;
  logic [3:0]  status, dest_out;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in),
    .s_in(s_in), .carry_in(carry_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .alu_res_out(alu_res_out), .val_rm_out(val_rm_out), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    freeze = 0; pc_in = 0; exe_cmd_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
    b_in = 0; s_in = 0; carry_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0;
    shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mov_shift(input logic [31:0] rm, input logic [11:0] so, input logic [31:0] exp, input string tag);
    clr(); exe_cmd_in = 4'b0001; val_rm_in = rm; shift_operand_in = so;
    tick();
    chk(tag, alu_res_out, exp);
  endtask
  initial begin
    clr();
    rst = 0; exe_cmd_in = 4'b0010; val_rn_in = 32'h5; wb_en_in = 1; s_in = 1; dest_in = 4'hA; mem_w_en_in = 1;
    #12;
    chk("rst_res", alu_res_out, 0);
    chk("rst_status", {28'b0, status}, 0);
    chk("rst_wb", {31'b0, wb_en_out}, 0);
    chk("rst_memw", {31'b0, mem_w_en_out}, 0);
    chk("rst_dest", {28'b0, dest_out}, 0);
    rst = 1;
    clr(); exe_cmd_in = 4'b0001; imm_in = 1; shift_operand_in = 12'h4FF; wb_en_in = 1; dest_in = 4'h3;
    tick();
    chk("mov_imm_rot", alu_res_out, 32'hFF000000);
    chk("mov_wb", {31'b0, wb_en_out}, 1);
    chk("mov_dest", {28'b0, dest_out}, 3);
    chk("mov_status", {28'b0, status}, 0);
    clr(); exe_cmd_in = 4'b0010; val_rn_in = 32'h7FFFFFFF; imm_in = 1; shift_operand_in = 12'h001; s_in = 1;
    tick();
    chk("adds_res", alu_res_out, 32'h80000000);
    chk("adds_status", {28'b0, status}, 32'h9);
    clr(); exe_cmd_in = 4'b0100; val_rn_in = 5; val_rm_in = 5; s_in = 1;
    tick();
    chk("subs_res", alu_res_out, 0);
    chk("subs_status", {28'b0, status}, 32'h6);
    clr(); exe_cmd_in = 4'b0101; val_rn_in = 5; val_rm_in = 3; carry_in = 0; s_in = 1;
    tick();
    chk("sbc_res", alu_res_out, 1);
    chk("sbc_status", {28'b0, status}, 32'h2);
    clr(); exe_cmd_in = 4'b1001; imm_in = 1; s_in = 1;
    tick();
    chk("mvn_res", alu_res_out, 32'hFFFFFFFF);
    chk("mvn_status_keeps_cv", {28'b0, status}, 32'hA);
    clr(); exe_cmd_in = 4'b1111; val_rn_in = 9; imm_in = 1; shift_operand_in = 12'h007; s_in = 1;
    tick();
    chk("undef_res", alu_res_out, 0);
    chk("undef_status", {28'b0, status}, 32'hA);
    clr(); exe_cmd_in = 4'b0110; val_rn_in = 32'hF0F0_1234; val_rm_in = 32'h0FF0_00FF;
    tick();
    chk("and_res", alu_res_out, 32'h00F0_0034);
    clr(); exe_cmd_in = 4'b1000; val_rn_in = 32'hFFFF_0000; val_rm_in = 32'h0F0F_0F0F;
    tick();
    chk("eor_res", alu_res_out, 32'hF0F0_0F0F);
    mov_shift(32'h80000000, 12'h240, 32'hF8000000, "asr4");
    mov_shift(32'h000000F1, 12'h260, 32'h1000000F, "ror4");
    mov_shift(32'h80000000, 12'hFA0, 32'h00000001, "lsr31");
    mov_shift(32'h80000001, 12'h080, 32'h00000002, "lsl1");
    mov_shift(32'hDEADBEEF, 12'h060, 32'hDEADBEEF, "ror0_pass");
    clr(); pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE; b_in = 1;
    #1;
    chk("br_taken", {31'b0, branch_taken}, 1);
    chk("br_addr", branch_addr, 32'hF8);
    freeze = 1;
    #1;
    chk("br_frozen", {31'b0, branch_taken}, 0);
    clr(); exe_cmd_in = 4'b0010; val_rn_in = 8; imm_in = 1; shift_operand_in = 12'h008; s_in = 1;
    tick();
    chk("frz_load", alu_res_out, 32'h10);
    chk("frz_load_status", {28'b0, status}, 0);
    clr(); freeze = 1; exe_cmd_in = 4'b0100; val_rn_in = 0; imm_in = 1; shift_operand_in = 12'h001; s_in = 1;
    for (int i = 0; i < 3; i++) begin
      val_rn_in = i;
      tick();
      chk("frz_hold_res", alu_res_out, 32'h10);
      chk("frz_hold_status", {28'b0, status}, 0);
    end
    freeze = 0; val_rn_in = 0;
    tick();
    chk("frz_release_res", alu_res_out, 32'hFFFFFFFF);
    chk("frz_release_status", {28'b0, status}, 32'h8);
    clr(); wb_en_in = 1; mem_w_en_in = 1;
    tick();
    clr();
    tick();
    chk("bubble_wb", {31'b0, wb_en_out}, 0);
    chk("bubble_memw", {31'b0, mem_w_en_out}, 0);
    chk("bubble_status", {28'b0, status}, 32'h8);
    clr(); exe_cmd_in = 4'b0010; mem_w_en_in = 1; shift_operand_in = 12'h804; val_rn_in = 32'h1000; val_rm_in = 32'hAB;
    tick();
    chk("str_addr", alu_res_out, 32'h1804);
    chk("str_data", val_rm_out, 32'hAB);
    chk("str_memw", {31'b0, mem_w_en_out}, 1);
    chk("str_memr", {31'b0, mem_r_en_out}, 0);
    clr(); exe_cmd_in = 4'b0010; mem_r_en_in = 1; wb_en_in = 1; shift_operand_in = 12'h010; val_rn_in = 32'h2000; dest_in = 4'h7;
    tick();
    chk("ldr_addr", alu_res_out, 32'h2010);
    chk("ldr_memr", {31'b0, mem_r_en_out}, 1);
    freeze = 1;
    #2 rst = 0;
    #1;
    chk("async_rst_res", alu_res_out, 0);
    chk("async_rst_memr", {31'b0, mem_r_en_out}, 0);
    chk("async_rst_dest", {28'b0, dest_out}, 0);
    chk("async_rst_status", {28'b0, status}, 0);
    rst = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
